// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: states, opcodes,
// datapath mux selects and the control word exchanged between decoder and top.
package mc_ctrl_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // pc_write and pc_write_cond stay separate so the top can fold in the ALU zero flag.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decoder. Moore except for FETCH, where
// the IR load and PC increment wait for the memory handshake.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = ALUB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut for a possible BRANCH.
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = ALUB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_write  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control: state register, opcode dispatch, retired
// instruction counter and reset gating of the decoded control word.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    ctrl_t            ctrl_raw;
    ctrl_t            ctrl_g;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // An illegal opcode returns to FETCH from DECODE and is deliberately not counted.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
            S_MEM_WRITE:                                   retire = mem_ready;
            default:                                       retire = 1'b0;
        endcase
        count_d = count_q + CNT_W'(retire);
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    assign ctrl_g = rst ? '0 : ctrl_raw;

    assign pc_en       = ctrl_g.pc_write | (ctrl_g.pc_write_cond & zero);
    assign i_or_d      = ctrl_g.i_or_d;
    assign mem_read    = ctrl_g.mem_read;
    assign mem_write   = ctrl_g.mem_write;
    assign ir_write    = ctrl_g.ir_write;
    assign reg_dst     = ctrl_g.reg_dst;
    assign mem_to_reg  = ctrl_g.mem_to_reg;
    assign reg_write   = ctrl_g.reg_write;
    assign alu_src_a   = ctrl_g.alu_src_a;
    assign alu_src_b   = ctrl_g.alu_src_b;
    assign alu_op      = ctrl_g.alu_op;
    assign pc_source   = ctrl_g.pc_source;
    assign illegal_op  = !rst && (state_q == S_DECODE) && !is_legal_op(opcode);
    assign state       = STATE_W'(state_q);
    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench: the driver pushes each cycle's expected outputs, derived
// from per-instruction step lists, and a negedge monitor pops and compares.
module tb_mc_ctrl_fsm;

    localparam int CW = 4;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_READ = 3;
    localparam int P_MEM_WB = 4, P_MEM_WRITE = 5, P_EXECUTE = 6, P_R_WB = 7;
    localparam int P_BRANCH = 8, P_JUMP = 9, P_ADDI_EXEC = 10, P_ADDI_WB = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic          mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]    alu_src_b, alu_op, pc_source;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    mc_ctrl_fsm #(.CNT_W(CW), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic [15:0]   ctrl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Order: pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    // alu_src_a,alu_src_b,alu_op,pc_source,illegal_op
    function automatic logic [15:0] expect_ctrl(input int p, input logic mr,
                                                input logic z, input logic [5:0] op);
        logic pe, iod, mrd, mwr, irw, rd, m2r, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pe, iod, mrd, mwr, irw, rd, m2r, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (p)
            P_FETCH:     begin mrd = 1; asb = 2'b01; irw = mr; pe = mr; end
            P_DECODE:    begin asb = 2'b11; ill = !legal(op); end
            P_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
            P_MEM_READ:  begin mrd = 1; iod = 1; end
            P_MEM_WB:    begin m2r = 1; rw = 1; end
            P_MEM_WRITE: begin mwr = 1; iod = 1; end
            P_EXECUTE:   begin asa = 1; aop = 2'b10; end
            P_R_WB:      begin rd = 1; rw = 1; end
            P_BRANCH:    begin asa = 1; aop = 2'b01; pe = z; psrc = 2'b01; end
            P_JUMP:      begin pe = 1; psrc = 2'b10; end
            P_ADDI_EXEC: begin asa = 1; asb = 2'b10; end
            P_ADDI_WB:   begin rw = 1; end
            default: ;
        endcase
        return {pe, iod, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
    endfunction

    task automatic cyc(input logic r, input int p, input logic mr, input logic z,
                       input logic [5:0] op);
        exp_t e;
        int   c;
        @(posedge clk);
        #1;
        rst = r; mem_ready = mr; zero = z; opcode = op;
        c = exp_cnt % (1 << CW);
        e.st   = 4'(p);
        e.ctrl = r ? 16'h0000 : expect_ctrl(p, mr, z, op);
        e.cnt  = CW'(c);
        sb_q.push_back(e);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction from FETCH back to FETCH; fw fetch stalls, mw memory stalls.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        for (int i = 0; i < fw; i++) cyc(1'b0, P_FETCH, 1'b0, rb(), 6'($urandom));
        cyc(1'b0, P_FETCH, 1'b1, rb(), 6'($urandom));
        cyc(1'b0, P_DECODE, rb(), rb(), op);
        case (op)
            6'b000000: begin cyc(0, P_EXECUTE, rb(), rb(), op); cyc(0, P_R_WB, rb(), rb(), op); end
            6'b100011: begin
                cyc(0, P_MEM_ADDR, rb(), rb(), op);
                for (int i = 0; i < mw; i++) cyc(0, P_MEM_READ, 1'b0, rb(), op);
                cyc(0, P_MEM_READ, 1'b1, rb(), op);
                cyc(0, P_MEM_WB, rb(), rb(), op);
            end
            6'b101011: begin
                cyc(0, P_MEM_ADDR, rb(), rb(), op);
                for (int i = 0; i < mw; i++) cyc(0, P_MEM_WRITE, 1'b0, rb(), op);
                cyc(0, P_MEM_WRITE, 1'b1, rb(), op);
            end
            6'b000100: cyc(0, P_BRANCH, rb(), z, op);
            6'b000010: cyc(0, P_JUMP, rb(), rb(), op);
            6'b001000: begin cyc(0, P_ADDI_EXEC, rb(), rb(), op); cyc(0, P_ADDI_WB, rb(), rb(), op); end
            default: ;
        endcase
        if (legal(op)) exp_cnt++;
        $display("instr op=%b fetch_wait=%0d mem_wait=%0d zero=%0b expected_count=%0d",
                 op, fw, mw, z, exp_cnt % (1 << CW));
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [15:0] act;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
            n_cmp++;
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL state at %0t: got %0d want %0d", $time, state, e.st);
            end
            n_cmp++;
            if (act !== e.ctrl) begin
                n_bad++;
                $display("FAIL ctrl at %0t (state %0d): got %b want %b", $time, e.st, act, e.ctrl);
            end
            n_cmp++;
            if (instr_count !== e.cnt) begin
                n_bad++;
                $display("FAIL instr_count at %0t: got %0d want %0d", $time, instr_count, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [7];
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b000010; ops[5] = 6'b001000; ops[6] = 6'b111111;

        // Two reset cycles: outputs all zero, state FETCH after the first edge.
        cyc(1'b1, P_FETCH, 1'b1, 1'b0, 6'd0);
        cyc(1'b1, P_FETCH, 1'b1, 1'b0, 6'd0);

        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 0, 3, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b000010, 1, 0, 1'b0);
        run_instr(6'b001000, 0, 0, 1'b0);
        run_instr(6'b101011, 0, 2, 1'b0);

        // Reset while in MEM_ADDR of a store: no write ever, counter cleared.
        cyc(1'b0, P_FETCH, 1'b1, 1'b0, 6'd0);
        cyc(1'b0, P_DECODE, 1'b1, 1'b0, 6'b101011);
        cyc(1'b1, P_MEM_ADDR, 1'b1, 1'b0, 6'b101011);
        exp_cnt = 0;
        $display("instr op=101011 aborted by reset in MEM_ADDR expected_count=0");

        for (int k = 0; k < 40; k++) begin
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2),
                      $urandom_range(0, 3), rb());
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS main control unit: a Moore FSM sequencing each instruction through fetch, decode, execute, memory and writeback.
- Directly upstream of the datapath 4:1 selectors:
  - alu_src_b drives the ALU-B source mux select.
  - pc_source drives the PC-source mux select.
- Also drives register-file, memory and IR enables.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- STATE_W, 4, width of the state register (12 states used).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory handshake; access completes on a cycle with mem_ready=1
- pc_en  out  1  PC load = pc_write | (pc_write_cond & zero)
- i_or_d  out  1  0: PC addresses memory, 1: ALUOut addresses memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  0: rt, 1: rd
- mem_to_reg  out  1  0: ALUOut, 1: MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0: PC, 1: reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decode
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target; 11 never driven
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state (debug)
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - rst=1 at a rising edge loads state=FETCH and instr_count=0.
  - While rst=1, every control output is forced to 0 combinationally; state reads FETCH after the first reset edge.
  - Reset mid-instruction aborts it with no writeback.
- Outputs: combinational decode of the state register only (Moore). Exceptions: pc_en (uses zero), FETCH strobes gated by mem_ready, and illegal_op (uses opcode).
- Any output not listed for a state is 0.
- FETCH (0):
  - Asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write assert only when mem_ready=1.
  - mem_ready=0: hold FETCH. mem_ready=1: go to DECODE.
- DECODE (1):
  - Asserts alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 -> EXECUTE
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - any other -> FETCH, with illegal_op=1 this cycle
- MEM_ADDR (2):
  - Asserts alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ (3): mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB (4): reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
- MEM_WRITE (5): mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
- EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB.
- R_WB (7): reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next FETCH.
- JUMP (9): pc_write=1, pc_source=10; next FETCH.
- ADDI_EXEC (10): alu_src_a=1, alu_src_b=10, alu_op=00; next ADDI_WB.
- ADDI_WB (11): reg_dst=0, mem_to_reg=0, reg_write=1; next FETCH.
- Unused encodings 12-15: next state FETCH, all outputs 0.
- Latency with mem_ready held at 1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
  - Each memory wait cycle adds 1.
- instr_count:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB. Not on the illegal DECODE->FETCH transition.
  - Wraps modulo 2^CNT_W.
  - rst takes priority over increment.
- The opcode register is owned by the IR; the FSM does not latch opcode.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings S_FETCH..S_ADDI_WB
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - mux select constants ALUB_REG, ALUB_FOUR, ALUB_IMM, ALUB_IMM_SH2
  - PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP
  - ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
- One natural sub-module: mc_ctrl_decode, the purely combinational state-to-control-word decoder. The top holds the state register, next-state logic and counter.

Test Plan:
- rst=1 for 2 cycles, then release, mem_ready=1 -> all outputs 0 during reset; cycle after release state=0, mem_read=1, ir_write=1, pc_en=1, alu_src_b=01; instr_count=0.
- opcode=000000, mem_ready=1 -> state sequence 0,1,6,7,0; alu_src_b 01,11,00; reg_write=1 and reg_dst=1 in state 7; instr_count 0->1.
- lw (100011) with mem_ready=0 for 3 cycles in MEM_READ -> state 3 held 4 cycles, then 4 with mem_to_reg=1; total 8 cycles.
- beq (000100): zero=1 -> pc_en=1, pc_source=01 in state 8. Repeat with zero=0 -> pc_en=0. instr_count +1 each.
- opcode=111111 -> illegal_op=1 for exactly one cycle in state 1; next state 0; instr_count unchanged.
- rst=1 while in MEM_ADDR during sw -> no mem_write ever asserted; state=0 and instr_count=0 next cycle.
